// File: rtl/fetch_if.sv
// Fetch unit bus bundle.
// Groups the redirect input, the instruction-cache request/response pair and
// the decode-side valid/ready queue port into one interface.
//   master : the fetch unit (drives icache_pc/rd_en/abort, inst_*, q_count)
//   slave  : the environment (drives redirect_*, icache_dout*, inst_ready)
interface fetch_if #(
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic [31:0]   icache_pc;
   logic          icache_rd_en;
   logic          icache_abort;
   logic [127:0]  icache_dout;
   logic          icache_dout_valid;
   logic [31:0]   inst_out;
   logic [31:0]   inst_pc;
   logic          inst_valid;
   logic          inst_ready;
   logic [CW-1:0] q_count;

   modport master (
      input  redirect_valid, redirect_pc, icache_dout, icache_dout_valid, inst_ready,
      output icache_pc, icache_rd_en, icache_abort, inst_out, inst_pc, inst_valid, q_count
   );

   modport slave (
      output redirect_valid, redirect_pc, icache_dout, icache_dout_valid, inst_ready,
      input  icache_pc, icache_rd_en, icache_abort, inst_out, inst_pc, inst_valid, q_count
   );
endinterface

// File: rtl/fetch_unit.sv
// Front-end fetch controller.
// Requests four-word lines from the instruction cache at fetch_pc, buffers
// the returned instructions (with their word addresses) in a DEPTH-entry
// circular queue and hands them to decode one per cycle over valid/ready.
// A redirect aborts the outstanding read, empties the queue and restarts
// fetch at the new address after a one-cycle flush.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - fetch_if.master: redirect_*, icache_*, inst_*, q_count
module fetch_unit #(
   parameter int          DEPTH    = 16,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic   clk,
   input  logic   rst_n,
   fetch_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, FETCH, STALL, FLUSH} state_t;

   state_t        state_q, state_d;
   logic [31:0]   fetch_pc_q;
   logic [PW-1:0] head_q, tail_q;
   logic [CW-1:0] count_q;

   logic [31:0]   inst_mem [DEPTH];
   logic [31:0]   pc_mem   [DEPTH];

   logic          space_ok;
   logic          rd_en;
   logic          abort;
   logic          inst_valid;
   logic          accept;
   logic          pop;

   // Room for a whole line, judged on the registered count only so that
   // rd_en never depends on this cycle's pop.
   assign space_ok = (CW'(DEPTH) - count_q) >= CW'(4);

   // NOTE: every output of a combinational block gets a default before the
   // case statement; a path that leaves one unassigned infers a latch.
   always_comb begin
      state_d = state_q;
      rd_en   = 1'b0;
      abort   = 1'b0;
      case (state_q)
         IDLE:  state_d = FETCH;
         FETCH: begin
            if (space_ok) rd_en = 1'b1;
            else          state_d = STALL;
         end
         STALL: if (space_ok) state_d = FETCH;
         FLUSH: begin
            abort   = 1'b1;
            state_d = FETCH;
         end
         default: state_d = IDLE;
      endcase
      // Redirect overrides everything, including a redirect while flushing.
      if (bus.redirect_valid) state_d = FLUSH;
   end

   // count is forced to zero on redirect, so FLUSH always shows an empty queue.
   assign inst_valid = (count_q != '0) && (state_q != FLUSH);

   // A line or pop coinciding with a redirect is dropped on the floor.
   assign accept = rd_en && bus.icache_dout_valid && !bus.redirect_valid;
   assign pop    = inst_valid && bus.inst_ready && !bus.redirect_valid;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         state_q <= state_d;
         if (bus.redirect_valid) begin
            fetch_pc_q <= bus.redirect_pc;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
         end else begin
            if (accept) begin
               fetch_pc_q <= fetch_pc_q + 32'd4;
               tail_q     <= tail_q + PW'(4);
            end
            if (pop) head_q <= head_q + PW'(1);
            case ({accept, pop})
               2'b10:   count_q <= count_q + CW'(4);
               2'b01:   count_q <= count_q - CW'(1);
               2'b11:   count_q <= count_q + CW'(3);
               default: count_q <= count_q;
            endcase
         end
      end
   end

   // NOTE: the queue storage has no reset; entries are only observed once
   // count says they were written, so clearing them would buy nothing.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < 4; k++) begin
            inst_mem[tail_q + PW'(k)] <= bus.icache_dout[32*k +: 32];
            pc_mem[tail_q + PW'(k)]   <= fetch_pc_q + 32'(k);
         end
      end
   end

   assign bus.icache_pc    = fetch_pc_q;
   assign bus.icache_rd_en = rd_en;
   assign bus.icache_abort = abort;
   assign bus.inst_valid   = inst_valid;
   assign bus.inst_out     = inst_mem[head_q];
   assign bus.inst_pc      = pc_mem[head_q];
   assign bus.q_count      = count_q;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Front-end fetch controller: issues line reads to the instruction cache (word address, four 32-bit instructions per line), buffers returned instructions in a DEPTH-entry instruction queue, and presents them one per cycle to decode with a valid/ready handshake. It sits between the branch/redirect logic and the instruction cache. On redirect it aborts the outstanding cache read, flushes the queue and restarts fetch at the new PC.

## Interface
- DEPTH, 16: queue entries (32-bit instructions); power of two, ≥ 8
- RESET_PC, 32'h0000_0000: word address fetched first after reset
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch word address
- icache_pc  out  32  word address of requested line (words pc..pc+3)
- icache_rd_en  out  1  line read request
- icache_abort  out  1  cancel outstanding read
- icache_dout  in  128  line data; word k in bits [32k+31:32k], address pc+k
- icache_dout_valid  in  1  line data valid
- inst_out  out  32  instruction at queue head
- inst_pc  out  32  word address of inst_out
- inst_valid  out  1  queue non-empty
- inst_ready  in  1  decode accepts head
- q_count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- State registers: state ∈ {IDLE, FETCH, STALL, FLUSH}, fetch_pc[31:0], head/tail pointers ($clog2(DEPTH) bits, wrap mod DEPTH), count.
- Reset (async): state=IDLE, fetch_pc=RESET_PC, count=0, pointers=0. Outputs during/after reset: icache_rd_en=0, icache_abort=0, inst_valid=0, q_count=0, icache_pc=RESET_PC.
- IDLE -> FETCH unconditionally next edge.
- FETCH: icache_rd_en=1 iff DEPTH-count ≥ 4 (count as registered, pop this cycle not credited); else state -> STALL. icache_pc=fetch_pc always; held stable while rd_en=1 until icache_dout_valid.
- Line accept = icache_rd_en && icache_dout_valid at an edge: words 0..3 written at tail..tail+3 with PCs fetch_pc+0..+3; tail+=4; fetch_pc+=4 (mod 2^32).
- STALL: rd_en=0; -> FETCH when DEPTH-count ≥ 4.
- Dequeue: inst_valid=(count≠0); pop when inst_valid && inst_ready; head+=1. Simultaneous accept and pop: count += 3. Never overflows or underflows.
- Redirect (any state, highest priority): at edge, count=0, head=tail=0, fetch_pc=redirect_pc, state -> FLUSH. Line accepted and pop in the same cycle are discarded/ignored (no write, queue empty after edge).
- FLUSH (one cycle): icache_abort=1, icache_rd_en=0, inst_valid=0; -> FETCH. Redirect during FLUSH reloads fetch_pc and stays in FLUSH one more cycle.
- redirect_pc need not be a multiple of 4; lines fetched from any word address.

## Timing
- icache_rd_en, icache_abort, inst_valid are combinational from registered state/count only (no path from icache_dout_valid or inst_ready).
- With zero-latency cache: rd_en and dout_valid same cycle; line accepted at that edge, first instruction inst_valid=1 the following cycle. Sustained fetch rate 1 line/cycle while space allows.
- Multi-cycle cache: rd_en held; accept on the edge where dout_valid=1.
- inst_out/inst_pc read combinationally from queue array at head.
- Redirect sampled at edge N: abort=1 during cycle N..N+1; rd_en=1 with icache_pc=redirect_pc from cycle after edge N+1; first redirected instruction valid after edge N+2 (zero-latency cache).

## Test plan
- Reset: rst_n low mid-fetch with count=9 -> immediately rd_en=0, inst_valid=0, q_count=0; after release, icache_pc=RESET_PC, rd_en=1 one cycle later.
- Streaming: zero-latency cache returning word value = address, inst_ready=1 -> inst_out sequence 0,1,2,…,63 with inst_pc equal, no gaps after initial fill.
- Backpressure: inst_ready=0 -> queue fills to 16 after 4 lines, rd_en=0 (STALL); pop 4 -> rd_en reasserts next cycle, fetch resumes at 0x10.
- Redirect: redirect_pc=0x200 with a line accepted same edge and count=7 -> q_count=0, abort=1 one cycle, next inst_out=mem[0x200], inst_pc=0x200; discarded line never appears.
- Back-to-back redirects 0x40 then 0x80 -> FLUSH two cycles, fetch starts at 0x80.
- Wrap: RESET_PC=32'hFFFF_FFFC -> inst_pc FFFF_FFFC..FFFF_FFFF then 0,1,2,3; multi-cycle cache (dout_valid after 3 cycles) keeps icache_pc stable during wait.
